// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D cache memory-port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 28;
  localparam int LINE_W_DEF = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // grant is {D,I}, one-hot or zero
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_I    = 2'b01;
  localparam logic [1:0] GNT_D    = 2'b10;

endpackage

// File: rtl/mem_arb_pick.sv
// Tie selector between I and D requests; returns a one-hot {D,I} grant.
// MEM_ARB_ROUND_ROBIN_EN selects alternating ties, otherwise D always wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       i_req_i,
  input  logic       d_req_i,
  input  logic       last_d_i,
  output logic [1:0] gnt_o
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_comb begin
    gnt_o = GNT_NONE;
    if (i_req_i && d_req_i) gnt_o = last_d_i ? GNT_I : GNT_D;
    else if (d_req_i)       gnt_o = GNT_D;
    else if (i_req_i)       gnt_o = GNT_I;
  end
`else
  // pointer only matters for round-robin ties
  logic unused_last_d;
  assign unused_last_d = last_d_i;

  always_comb begin
    gnt_o = GNT_NONE;
    if (d_req_i)      gnt_o = GNT_D;
    else if (i_req_i) gnt_o = GNT_I;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// One-at-a-time arbiter sharing the memory port between I- and D-cache engines.
// Tie policy is fixed D-priority unless MEM_ARB_ROUND_ROBIN_EN is defined.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              I_req,
  input  logic [ADDR_W-1:0] I_addr,
  output logic              I_ready,
  output logic [LINE_W-1:0] I_rdata,
  input  logic              D_req,
  input  logic              D_wen,
  input  logic [ADDR_W-1:0] D_addr,
  input  logic [LINE_W-1:0] D_wdata,
  output logic              D_ready,
  output logic [LINE_W-1:0] D_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        grant
);

  state_e            state_q, state_d;
  logic [1:0]        grant_q, grant_d, pick;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d, line_q, line_d;
  logic              wen_q, wen_d, rd_q, rd_d, wr_q, wr_d;
  logic              i_rdy_q, i_rdy_d, d_rdy_q, d_rdy_d;
  logic              last_d_q, last_d_d;

  mem_arb_pick u_pick (
    .i_req_i  (I_req),
    .d_req_i  (D_req),
    .last_d_i (last_d_q),
    .gnt_o    (pick)
  );

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wen_d    = wen_q;
    line_d   = line_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    i_rdy_d  = 1'b0;
    d_rdy_d  = 1'b0;
    last_d_d = last_d_q;
    case (state_q)
      ST_IDLE: if (pick != GNT_NONE) begin
        grant_d  = pick;
        last_d_d = pick[1];
        if (pick[1]) begin
          addr_d  = D_addr;
          wdata_d = D_wdata;
          wen_d   = D_wen;
        end else begin
          addr_d  = I_addr;
          wen_d   = 1'b0;
        end
        rd_d    = ~wen_d;
        wr_d    = wen_d;
        state_d = ST_BUSY;
      end
      ST_BUSY: if (mem_ready) begin
        if (!wen_q) line_d = mem_rdata;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        i_rdy_d = grant_q[0];
        d_rdy_d = grant_q[1];
        state_d = ST_DONE;
      end
      ST_DONE: begin
        grant_d = GNT_NONE;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= GNT_NONE;
      addr_q   <= '0;
      wdata_q  <= '0;
      wen_q    <= 1'b0;
      line_q   <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      i_rdy_q  <= 1'b0;
      d_rdy_q  <= 1'b0;
      last_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wen_q    <= wen_d;
      line_q   <= line_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      i_rdy_q  <= i_rdy_d;
      d_rdy_q  <= d_rdy_d;
      last_d_q <= last_d_d;
    end
  end

  assign I_ready   = i_rdy_q;
  assign D_ready   = d_rdy_q;
  assign I_rdata   = line_q;
  assign D_rdata   = line_q;
  assign mem_read  = rd_q;
  assign mem_write = wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign grant     = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; tie expectations follow MEM_ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         I_req, D_req, D_wen, mem_ready;
  logic [27:0]  I_addr, D_addr, mem_addr;
  logic [127:0] D_wdata, mem_rdata, I_rdata, D_rdata, mem_wdata;
  logic         I_ready, D_ready, mem_read, mem_write;
  logic [1:0]   grant;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] LINE_BEEF = {4{32'hDEADBEEF}};
  localparam logic [127:0] LINE_A5   = {16{8'hA5}};
  localparam logic [127:0] LINE_X1   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] LINE_X2   = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .I_req(I_req), .I_addr(I_addr), .I_ready(I_ready), .I_rdata(I_rdata),
    .D_req(D_req), .D_wen(D_wen), .D_addr(D_addr), .D_wdata(D_wdata),
    .D_ready(D_ready), .D_rdata(D_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .grant(grant)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; I_req = 1'b0; D_req = 1'b0; D_wen = 1'b0; mem_ready = 1'b0;
    I_addr = '0; D_addr = '0; D_wdata = '0; mem_rdata = '0;
    #12;
    chk("rst_grant", 128'(grant), 128'(0));
    chk("rst_mrd",   128'(mem_read), 128'(0));
    chk("rst_mwr",   128'(mem_write), 128'(0));
    chk("rst_irdy",  128'(I_ready), 128'(0));
    chk("rst_drdy",  128'(D_ready), 128'(0));
    chk("rst_maddr", 128'(mem_addr), 128'(0));
    chk("rst_wdata", mem_wdata, 128'(0));
    chk("rst_line",  I_rdata, 128'(0));
    @(negedge clk); rst_n = 1'b1;
    step();

    // lone I read, 3 BUSY cycles
    I_req = 1'b1; I_addr = 28'h0000010;
    step();
    chk("t1_rd_c1", 128'(mem_read), 128'(1));
    chk("t1_wr_c1", 128'(mem_write), 128'(0));
    chk("t1_addr",  128'(mem_addr), 128'(28'h0000010));
    chk("t1_grant", 128'(grant), 128'(2'b01));
    step();
    chk("t1_rd_c2", 128'(mem_read), 128'(1));
    step();
    chk("t1_rd_c3", 128'(mem_read), 128'(1));
    mem_ready = 1'b1; mem_rdata = LINE_BEEF;
    step();
    mem_ready = 1'b0; I_req = 1'b0;
    chk("t1_irdy",  128'(I_ready), 128'(1));
    chk("t1_idata", I_rdata, LINE_BEEF);
    chk("t1_drdy",  128'(D_ready), 128'(0));
    chk("t1_rd_c4", 128'(mem_read), 128'(0));
    step();
    chk("t1_irdy_off", 128'(I_ready), 128'(0));
    chk("t1_gnt_off",  128'(grant), 128'(0));

    // D write-back, zero-wait memory
    D_req = 1'b1; D_wen = 1'b1; D_addr = 28'h0000020; D_wdata = LINE_A5;
    step();
    chk("t2_wr",    128'(mem_write), 128'(1));
    chk("t2_rd",    128'(mem_read), 128'(0));
    chk("t2_addr",  128'(mem_addr), 128'(28'h0000020));
    chk("t2_wdata", mem_wdata, LINE_A5);
    chk("t2_grant", 128'(grant), 128'(2'b10));
    mem_ready = 1'b1; mem_rdata = LINE_X2;
    step();
    mem_ready = 1'b0; D_req = 1'b0; D_wen = 1'b0;
    chk("t2_drdy",  128'(D_ready), 128'(1));
    chk("t2_irdy",  128'(I_ready), 128'(0));
    chk("t2_wr_c2", 128'(mem_write), 128'(0));
    chk("t2_rd_c2", 128'(mem_read), 128'(0));
    chk("t2_line",  D_rdata, LINE_BEEF);
    step();

    // mem_ready in IDLE is ignored
    mem_ready = 1'b1;
    step();
    chk("t4_idle_gnt",  128'(grant), 128'(0));
    chk("t4_idle_irdy", 128'(I_ready), 128'(0));
    chk("t4_idle_drdy", 128'(D_ready), 128'(0));
    chk("t4_idle_rd",   128'(mem_read), 128'(0));
    // mem_ready held through BUSY and DONE
    I_req = 1'b1; I_addr = 28'h0000070; mem_rdata = LINE_X2;
    step();
    chk("t4_busy_rd", 128'(mem_read), 128'(1));
    step();
    I_req = 1'b0;
    chk("t4_done_irdy", 128'(I_ready), 128'(1));
    chk("t4_done_data", I_rdata, LINE_X2);
    step();
    chk("t4_post_irdy", 128'(I_ready), 128'(0));
    chk("t4_post_drdy", 128'(D_ready), 128'(0));
    chk("t4_post_gnt",  128'(grant), 128'(0));
    chk("t4_post_rd",   128'(mem_read), 128'(0));
    mem_ready = 1'b0;

    // D request arriving during an I transaction waits
    I_req = 1'b1; I_addr = 28'h0000030;
    step();
    D_req = 1'b1; D_wen = 1'b0; D_addr = 28'h0000040;
    step();
    chk("t6_gnt_busy", 128'(grant), 128'(2'b01));
    chk("t6_addr_fix", 128'(mem_addr), 128'(28'h0000030));
    mem_ready = 1'b1; mem_rdata = LINE_X1;
    step();
    mem_ready = 1'b0; I_req = 1'b0;
    chk("t6_irdy", 128'(I_ready), 128'(1));
    chk("t6_drdy", 128'(D_ready), 128'(0));
    step();
    chk("t6_idle_gnt", 128'(grant), 128'(0));
    step();
    chk("t6_dgnt",  128'(grant), 128'(2'b10));
    chk("t6_drd",   128'(mem_read), 128'(1));
    chk("t6_daddr", 128'(mem_addr), 128'(28'h0000040));
    mem_ready = 1'b1; mem_rdata = LINE_A5;
    step();
    mem_ready = 1'b0; D_req = 1'b0;
    chk("t6_drdy2", 128'(D_ready), 128'(1));
    chk("t6_ddata", D_rdata, LINE_A5);
    step();

    // asynchronous reset mid-BUSY
    I_req = 1'b1; I_addr = 28'h0000050;
    step();
    chk("t5_rd_pre", 128'(mem_read), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rd_rst",   128'(mem_read), 128'(0));
    chk("t5_gnt_rst",  128'(grant), 128'(0));
    chk("t5_addr_rst", 128'(mem_addr), 128'(0));
    chk("t5_line_rst", I_rdata, 128'(0));
    I_addr = 28'h0000060;
    @(negedge clk); rst_n = 1'b1;
    step();
    chk("t5_rd_new",   128'(mem_read), 128'(1));
    chk("t5_addr_new", 128'(mem_addr), 128'(28'h0000060));
    chk("t5_gnt_new",  128'(grant), 128'(2'b01));
    mem_ready = 1'b1; mem_rdata = LINE_X1;
    step();
    mem_ready = 1'b0; I_req = 1'b0;
    chk("t5_irdy", 128'(I_ready), 128'(1));
    step();

    // both sides requesting continuously, zero-wait memory
    // (the I transaction above leaves the pointer at I-last)
    I_req = 1'b1; D_req = 1'b1; D_wen = 1'b0; mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] exp_g;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
`else
      exp_g = 2'b10;
`endif
      step();
      chk($sformatf("t3_gnt%0d", k), 128'(grant), 128'(exp_g));
      step();
      chk($sformatf("t3_rdy%0d", k), 128'({D_ready, I_ready}), 128'(exp_g));
      step();
    end
    I_req = 1'b0; D_req = 1'b0; mem_ready = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
